// File: rtl/i2c_master_burst.sv
// rtl/i2c_master_burst.sv - I2C burst master: START, address, N write/read bytes, STOP
// Purpose: runs one I2C transaction per accepted command; SCL bits are built from
//   four quarter-period ticks (Q0/Q1 sclk low, Q2/Q3 sclk high).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   cmd_valid/cmd_ready       - command handshake (ready only in IDLE)
//   cmd_addr, cmd_rw, cmd_len - 7-bit slave address, 1=read, byte count (0 = probe)
//   wr_data/wr_valid/wr_ready - write byte source, wr_ready pulses on consume
//   rd_data/rd_valid          - received byte, rd_valid pulses per byte
//   busy, done, nack, state   - status and debug state encoding
//   sclk, sda_out, sda_in     - bus clock, driven data (1 = release), sampled data
module i2c_master_burst #(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [6:0]       cmd_addr,
  input  logic             cmd_rw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             busy,
  output logic             done,
  output logic             nack,
  output logic [3:0]       state,
  output logic             sclk,
  output logic             sda_out,
  input  logic             sda_in
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_START = 4'd1, S_ADDR = 4'd2, S_ADDR_ACK = 4'd3, S_WRITE = 4'd4,
    S_WRITE_ACK = 4'd5, S_READ = 4'd6, S_READ_ACK = 4'd7, S_STOP = 4'd8
  } state_t;

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  state_t           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [2:0]       bit_q, bit_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic             rw_q, rw_d;
  logic             ack_q, ack_d;
  logic             loaded_q, loaded_d;
  logic             nack_q, nack_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             done_q, done_d;
  logic             hold, freeze, tick, bit_end;

  // A WRITE byte cannot start until its data byte has been taken; while waiting
  // the quarter/tick counters stand still with sclk low.
  assign hold    = (state_q == S_WRITE) && (bit_q == 3'd0) && (qtr_q == 2'd0) && !loaded_q;
  assign freeze  = hold && !wr_valid;
  assign tick    = (state_q != S_IDLE) && !freeze && (div_q == DIV_MAX);
  assign bit_end = tick && (qtr_q == 2'd3);

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign wr_ready  = hold && wr_valid;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign nack      = nack_q;
  assign state     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      cnt_q      <= '0;
      sh_q       <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      loaded_q   <= 1'b0;
      nack_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      loaded_q   <= loaded_d;
      nack_q     <= nack_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    qtr_d      = qtr_q;
    bit_d      = bit_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    loaded_d   = loaded_q;
    nack_d     = nack_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;

    if (state_q == S_IDLE) begin
      div_d = '0;
      qtr_d = '0;
    end else if (!freeze) begin
      if (tick) begin
        div_d = '0;
        qtr_d = qtr_q + 2'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end

    if (hold && wr_valid) begin
      sh_d     = wr_data;
      loaded_d = 1'b1;
    end

    // Bus data is sampled at the end of Q2, the first high quarter.
    if (tick && (qtr_q == 2'd2)) begin
      ack_d = sda_in;
      if (state_q == S_READ) sh_d = {sh_q[6:0], sda_in};
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_START;
          sh_d    = {cmd_addr, cmd_rw};
          rw_d    = cmd_rw;
          cnt_d   = cmd_len;
          bit_d   = '0;
          nack_d  = 1'b0;
        end
      end
      S_START: if (bit_end) state_d = S_ADDR;
      S_ADDR, S_WRITE: begin
        if (bit_end) begin
          sh_d = {sh_q[6:0], 1'b0};
          if (bit_q == 3'd7) begin
            bit_d    = '0;
            loaded_d = 1'b0;
            state_d  = (state_q == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_ADDR_ACK: begin
        if (bit_end) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else if (cnt_q == '0) begin
            state_d = S_STOP;
          end else begin
            state_d = rw_q ? S_READ : S_WRITE;
          end
        end
      end
      S_WRITE_ACK: begin
        if (bit_end) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
          end else begin
            cnt_d   = cnt_q - LEN_W'(1);
            state_d = (cnt_q == LEN_W'(1)) ? S_STOP : S_WRITE;
          end
        end
      end
      S_READ: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d      = '0;
            rd_data_d  = sh_q;
            rd_valid_d = 1'b1;
            state_d    = S_READ_ACK;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_READ_ACK: begin
        if (bit_end) begin
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? S_STOP : S_READ;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Bus pins are decoded from registered state, so data only moves when the
  // bit index changes, which happens on entry to Q0.
  always_comb begin
    sclk    = 1'b1;
    sda_out = 1'b1;
    case (state_q)
      S_IDLE: begin
        sclk    = 1'b1;
        sda_out = 1'b1;
      end
      S_START: begin
        sclk    = ~qtr_q[1];
        sda_out = 1'b0;
      end
      S_ADDR: begin
        sclk    = qtr_q[1];
        sda_out = sh_q[7];
      end
      S_WRITE: begin
        sclk    = qtr_q[1];
        sda_out = loaded_q ? sh_q[7] : 1'b1;
      end
      S_READ_ACK: begin
        sclk    = qtr_q[1];
        sda_out = (cnt_q == LEN_W'(1));
      end
      S_STOP: begin
        sclk    = (qtr_q != 2'd0);
        sda_out = qtr_q[1];
      end
      default: begin
        sclk    = qtr_q[1];
        sda_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master_burst.sv
// tb/tb_i2c_master_burst.sv - self-checking bench for i2c_master_burst with a slave model
module tb_i2c_master_burst;

  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic       wr_valid = 1'b0, sda_in = 1'b1;
  logic [6:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic [7:0] wr_data = '0;
  logic       cmd_ready, wr_ready, rd_valid, busy, done, nack, sclk, sda_out;
  logic [7:0] rd_data;
  logic [3:0] state;

  i2c_master_burst #(.CLK_DIV(2), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done), .nack(nack),
    .state(state), .sclk(sclk), .sda_out(sda_out), .sda_in(sda_in)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave configuration and observations
  logic       s_rw = 1'b0, s_an = 1'b0;
  int         s_len = 0;
  logic [7:0] s_rdata [16];
  logic [7:0] tw [16];
  logic       bits [$];
  logic       exp_bits [$];
  int         rises [$];
  logic [7:0] rd_q [$];
  logic [7:0] exp_rd [$];
  logic [7:0] wq [$];
  int         k = 0, starts = 0, stops = 0, dones = 0, wr_pulses = 0;
  logic       last_nack = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1, tmo = 1'b0;
  logic       stall_en = 1'b0, seen_wack = 1'b0, stalling = 1'b0, wr_take = 1'b0;
  int         stall_cnt = 0, stall_bad = 0;

  // Slave drive for SCL pulse k of the transaction (9 pulses per byte).
  function automatic logic slave_bit(int kk);
    int byt, pos;
    byt = kk / 9;
    pos = kk % 9;
    if (byt == 0) return (pos == 8) ? s_an : 1'b1;
    if (s_an || byt > s_len) return 1'b1;
    if (s_rw) return (pos < 8) ? s_rdata[byt-1][7-pos] : 1'b1;
    return (pos == 8) ? 1'b0 : 1'b1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_scl = 1'b1;
      prev_sda = 1'b1;
      sda_in   = 1'b1;
      k        = 0;
    end else begin
      if (sclk && prev_scl && prev_sda && !sda_out) begin
        starts++;
        bits.delete();
        rises.delete();
        k = 0;
      end
      if (sclk && prev_scl && !prev_sda && sda_out) stops++;
      if (sclk && !prev_scl) begin
        bits.push_back(sda_out & sda_in);
        rises.push_back(cyc);
        k++;
      end
      if (!sclk && prev_scl) sda_in = slave_bit(k);
      if (rd_valid) rd_q.push_back(rd_data);
      if (done) begin
        dones++;
        last_nack = nack;
      end
      prev_scl = sclk;
      prev_sda = sda_out;
    end
  end

  // Write-data source: presents the queue head whenever it has data, except for
  // an optional 20-cycle withhold at the second byte start.
  always @(negedge clk) begin
    if (wr_take) begin
      if (wq.size() > 0) void'(wq.pop_front());
      wr_pulses++;
      wr_take = 1'b0;
    end
    if (state == 4'd5 && wr_pulses == 1) seen_wack = 1'b1;
    stalling = stall_en && seen_wack && (wr_pulses == 1) && (state == 4'd4) && (stall_cnt < 20);
    if (stalling) begin
      stall_cnt++;
      if (sclk !== 1'b0) stall_bad++;
    end
    wr_valid = (wq.size() > 0) && !stalling;
    wr_data  = (wq.size() > 0) ? wq[0] : 8'h00;
    #1;
    if (wr_ready === 1'b1) wr_take = 1'b1;
    if (stalling && wr_ready !== 1'b0) stall_bad++;
  end

  function automatic int bits_bad();
    int n = 0;
    if (bits.size() != exp_bits.size()) return 1000 + bits.size();
    foreach (exp_bits[i]) if (bits[i] !== exp_bits[i]) n++;
    return n;
  endfunction

  function automatic int rd_bad();
    int n = 0;
    if (rd_q.size() != exp_rd.size()) return 1000 + rd_q.size();
    foreach (exp_rd[i]) if (rd_q[i] !== exp_rd[i]) n++;
    return n;
  endfunction

  function automatic int timing_bad();
    int n = 0;
    for (int i = 1; i < rises.size() - 1; i++) if (rises[i] - rises[i-1] != 8) n++;
    return n;
  endfunction

  task automatic clear_obs();
    wr_pulses = 0; dones = 0; starts = 0; stops = 0; rd_q.delete();
    stall_cnt = 0; stall_bad = 0; seen_wack = 0; wr_take = 0; tmo = 0;
  endtask

  // Builds the expected bus trace from the transaction description, then runs it.
  task automatic do_xfer(input logic [6:0] a, input logic rw, input int len,
                         input logic an, input logic stl);
    logic [7:0] ab, d;
    int w;
    ab = {a, rw};
    exp_bits.delete();
    exp_rd.delete();
    for (int i = 7; i >= 0; i--) exp_bits.push_back(ab[i]);
    exp_bits.push_back(an);
    if (!an) begin
      for (int b = 0; b < len; b++) begin
        d = rw ? s_rdata[b] : tw[b];
        for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
        exp_bits.push_back(rw ? (b == len - 1) : 1'b0);
        if (rw) exp_rd.push_back(d);
      end
    end
    exp_bits.push_back(1'b0);
    @(posedge clk); #2;
    wq.delete();
    if (!rw) for (int b = 0; b < len; b++) wq.push_back(tw[b]);
    s_rw = rw; s_len = len; s_an = an; stall_en = stl;
    clear_obs();
    cmd_addr = a; cmd_rw = rw; cmd_len = 4'(len); cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    w = 0;
    while (dones == 0 && w < 4000) begin
      @(posedge clk);
      w++;
    end
    tmo = (dones == 0);
    repeat (3) @(posedge clk);
    #2;
    wq.delete();
    stall_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_chk++; if (state !== 4'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_chk++; if ({sclk, sda_out} !== 2'b11) begin n_fail++; $display("FAIL reset_bus: got sclk/sda %b want 11", {sclk, sda_out}); end
    n_chk++; if ({busy, done, nack, rd_valid, wr_ready} !== 5'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy, done, nack, rd_valid, wr_ready}); end
    n_chk++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
    rst = 1'b0;
    @(posedge clk); #2;
    n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
  endtask

  task automatic test_write();
    tw[0] = 8'hA5; tw[1] = 8'h3C;
    do_xfer(7'h5A, 1'b0, 2, 1'b0, 1'b0);
    n_chk++; if (tmo) begin n_fail++; $display("FAIL write_done: got done=0 want done=1"); end
    n_chk++; if (bits_bad() != 0) begin n_fail++; $display("FAIL write_bits: got %0d bad bits want 0", bits_bad()); end
    n_chk++; if (wr_pulses != 2) begin n_fail++; $display("FAIL write_wr_ready: got %0d pulses want 2", wr_pulses); end
    n_chk++; if (last_nack !== 1'b0) begin n_fail++; $display("FAIL write_nack: got %b want 0", last_nack); end
    n_chk++; if (timing_bad() != 0) begin n_fail++; $display("FAIL write_bit_time: got %0d bits not 8 cycles want 0", timing_bad()); end
    n_chk++; if (starts != 1 || stops != 1) begin n_fail++; $display("FAIL write_start_stop: got %0d/%0d want 1/1", starts, stops); end
  endtask

  task automatic test_read();
    s_rdata[0] = 8'h11; s_rdata[1] = 8'h22; s_rdata[2] = 8'h33;
    do_xfer(7'h5A, 1'b1, 3, 1'b0, 1'b0);
    n_chk++; if (tmo) begin n_fail++; $display("FAIL read_done: got done=0 want done=1"); end
    n_chk++; if (bits_bad() != 0) begin n_fail++; $display("FAIL read_bits: got %0d bad bits want 0", bits_bad()); end
    n_chk++; if (rd_bad() != 0) begin n_fail++; $display("FAIL read_data: got %0d bad bytes want 0", rd_bad()); end
    n_chk++; if (last_nack !== 1'b0) begin n_fail++; $display("FAIL read_nack: got %b want 0", last_nack); end
  endtask

  task automatic test_addr_nack();
    tw[0] = 8'($urandom); tw[1] = 8'($urandom);
    do_xfer(7'($urandom), 1'b0, 2, 1'b1, 1'b0);
    n_chk++; if (bits_bad() != 0) begin n_fail++; $display("FAIL nack_bits: got %0d bad bits want 0", bits_bad()); end
    n_chk++; if (last_nack !== 1'b1 || dones != 1) begin n_fail++; $display("FAIL nack_flag: got nack=%b dones=%0d want 1/1", last_nack, dones); end
    n_chk++; if (wr_pulses != 0) begin n_fail++; $display("FAIL nack_wr_ready: got %0d pulses want 0", wr_pulses); end
    @(posedge clk); #2;
    n_chk++; if (nack !== 1'b1) begin n_fail++; $display("FAIL nack_hold: got %b want 1", nack); end
  endtask

  task automatic test_probe();
    do_xfer(7'h5A, 1'($urandom), 0, 1'b0, 1'b0);
    n_chk++; if (nack !== 1'b0) begin n_fail++; $display("FAIL probe_nack_clear: got %b want 0", nack); end
    n_chk++; if (bits_bad() != 0) begin n_fail++; $display("FAIL probe_bits: got %0d bad bits want 0", bits_bad()); end
    n_chk++; if (dones != 1 || starts != 1 || stops != 1) begin n_fail++; $display("FAIL probe_frame: got done/start/stop %0d/%0d/%0d want 1/1/1", dones, starts, stops); end
  endtask

  task automatic test_stall();
    for (int b = 0; b < 3; b++) tw[b] = 8'($urandom);
    do_xfer(7'($urandom), 1'b0, 3, 1'b0, 1'b1);
    n_chk++; if (stall_cnt != 20 || stall_bad != 0) begin n_fail++; $display("FAIL stall_sclk: got %0d cycles %0d bad want 20 cycles 0 bad", stall_cnt, stall_bad); end
    n_chk++; if (bits_bad() != 0) begin n_fail++; $display("FAIL stall_bits: got %0d bad bits want 0", bits_bad()); end
    n_chk++; if (wr_pulses != 3 || tmo) begin n_fail++; $display("FAIL stall_wr_ready: got %0d pulses want 3", wr_pulses); end
  endtask

  task automatic test_max_len();
    for (int b = 0; b < 15; b++) begin tw[b] = 8'($urandom); s_rdata[b] = 8'($urandom); end
    do_xfer(7'($urandom), 1'b0, 15, 1'b0, 1'b0);
    n_chk++; if (bits_bad() != 0 || wr_pulses != 15) begin n_fail++; $display("FAIL maxlen_write: got %0d bad bits %0d pulses want 0/15", bits_bad(), wr_pulses); end
    do_xfer(7'($urandom), 1'b1, 15, 1'b0, 1'b0);
    n_chk++; if (bits_bad() != 0 || rd_bad() != 0) begin n_fail++; $display("FAIL maxlen_read: got %0d bad bits %0d bad bytes want 0/0", bits_bad(), rd_bad()); end
  endtask

  task automatic test_busy_ignore();
    int w;
    @(posedge clk); #2;
    wq.delete(); wq.push_back(8'h6E);
    s_rw = 1'b0; s_len = 1; s_an = 1'b0;
    clear_obs();
    cmd_addr = 7'h21; cmd_rw = 1'b0; cmd_len = 4'd1; cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    n_chk++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_fail++; $display("FAIL busy_flags: got busy=%b ready=%b want 1/0", busy, cmd_ready); end
    cmd_addr = 7'h33; cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    w = 0;
    while (dones == 0 && w < 4000) begin @(posedge clk); w++; end
    repeat (100) @(posedge clk);
    #2;
    n_chk++; if (starts != 1 || dones != 1 || busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore: got starts=%0d dones=%0d busy=%b want 1/1/0", starts, dones, busy); end
  endtask

  task automatic test_reset_mid();
    int w;
    @(posedge clk); #2;
    wq.delete(); wq.push_back(8'h77);
    s_rw = 1'b0; s_len = 1; s_an = 1'b0;
    clear_obs();
    cmd_addr = 7'h5A; cmd_rw = 1'b0; cmd_len = 4'd1; cmd_valid = 1'b1;
    @(posedge clk); #2;
    cmd_valid = 1'b0;
    w = 0;
    while (rises.size() < 4 && w < 2000) begin @(posedge clk); w++; end
    #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    n_chk++; if ({sclk, sda_out} !== 2'b11 || state !== 4'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got sclk/sda %b state %0d busy %b want 11/0/0", {sclk, sda_out}, state, busy); end
    n_chk++; if (rd_data !== 8'h00 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_regs: got rd_data %h done %b want 00/0", rd_data, done); end
    wq.delete();
    repeat (40) @(posedge clk);
    #2;
    n_chk++; if (dones != 0 || sclk !== 1'b1) begin n_fail++; $display("FAIL midrst_no_done: got dones=%0d sclk=%b want 0/1", dones, sclk); end
    s_rdata[0] = 8'($urandom); s_rdata[1] = 8'($urandom);
    do_xfer(7'($urandom), 1'b1, 2, 1'b0, 1'b0);
    n_chk++; if (bits_bad() != 0 || rd_bad() != 0 || tmo) begin n_fail++; $display("FAIL midrst_recover: got %0d bad bits %0d bad bytes want 0/0", bits_bad(), rd_bad()); end
  endtask

  task automatic test_random();
    logic rw, an;
    int len;
    for (int t = 0; t < 8; t++) begin
      rw  = 1'($urandom);
      an  = ($urandom_range(0, 4) == 0);
      len = $urandom_range(0, 5);
      for (int b = 0; b < 16; b++) begin tw[b] = 8'($urandom); s_rdata[b] = 8'($urandom); end
      do_xfer(7'($urandom), rw, len, an, 1'b0);
      n_chk++; if (bits_bad() != 0) begin n_fail++; $display("FAIL rand%0d_bits: got %0d bad bits want 0", t, bits_bad()); end
      n_chk++; if (rd_bad() != 0) begin n_fail++; $display("FAIL rand%0d_rd: got %0d bad bytes want 0", t, rd_bad()); end
      n_chk++; if (wr_pulses != ((an || rw) ? 0 : len)) begin n_fail++; $display("FAIL rand%0d_wr: got %0d pulses want %0d", t, wr_pulses, (an || rw) ? 0 : len); end
      n_chk++; if (dones != 1 || last_nack !== an) begin n_fail++; $display("FAIL rand%0d_done: got dones=%0d nack=%b want 1/%b", t, dones, last_nack, an); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_probe();
    test_stall();
    test_max_len();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish want finish before 90000 cycles");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_master_burst.md
I2C_MASTER_BURST -- requirements
Module: i2c_master_burst

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL quarter-period (legal range 1..255).
REQ-002 SHALL have parameter LEN_W, default 4: width of the byte-count field.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input, rst input.
REQ-004 SHALL have port clk  input  1  system clock; all logic on posedge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  command request.
REQ-007 SHALL have port cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready.
REQ-008 SHALL have port cmd_addr  input  7  slave address.
REQ-009 SHALL have port cmd_rw  input  1  1 = read, 0 = write.
REQ-010 SHALL have port cmd_len  input  LEN_W  byte count; 0 = address-only probe.
REQ-011 SHALL have port wr_data  input  8  write byte.
REQ-012 SHALL have port wr_valid  input  1  wr_data valid.
REQ-013 SHALL have port wr_ready  output  1  one-cycle pulse when wr_data is consumed.
REQ-014 SHALL have port rd_data  output  8  received byte, held until the next byte.
REQ-015 SHALL have port rd_valid  output  1  one-cycle pulse per received byte.
REQ-016 SHALL have port busy  output  1  high from command accept until return to IDLE.
REQ-017 SHALL have port done  output  1  one-cycle pulse on return to IDLE.
REQ-018 SHALL have port nack  output  1  error flag; valid with done.
REQ-019 SHALL have port state  output  4  current FSM state encoding, for debug.
REQ-020 SHALL have port sclk  output  1  serial clock.
REQ-021 SHALL have port sda_out  output  1  serial data driven by the master; 1 = release.
REQ-022 SHALL have port sda_in  input  1  sampled bus data.

Function
REQ-023 Tick SHALL pulse every CLK_DIV clk cycles while busy; each SCL bit SHALL be 4 ticks: Q0 and Q1 with sclk=0, Q2 and Q3 with sclk=1.
REQ-024 sda_out SHALL change only at the Q0 tick; sda_in SHALL be sampled at the end of Q2.
REQ-025 FSM states SHALL be IDLE=0, START=1, ADDR=2, ADDR_ACK=3, WRITE=4, WRITE_ACK=5, READ=6, READ_ACK=7, STOP=8.
REQ-026 In IDLE, sclk and sda_out SHALL be held at 1.
REQ-027 On command accept, the block SHALL latch addr, rw and len and enter START.
REQ-028 START SHALL drive sda_out=0 while sclk=1 for 2 ticks, then sclk=0 for 2 ticks, then enter ADDR.
REQ-029 ADDR SHALL shift out {cmd_addr, cmd_rw} as 8 bits, MSB first, then enter ADDR_ACK.
REQ-030 In ADDR_ACK, the block SHALL release sda_out and sample sda_in.
  - 1 (NACK): set nack, go to STOP.
  - 0 with len=0: go to STOP.
  - 0 with len>0: go to WRITE or READ per rw.
REQ-031 At each WRITE byte start, if wr_valid=0 the block SHALL hold sclk=0 and freeze the tick counter until wr_valid=1.
REQ-032 On wr_valid=1 at a WRITE byte start, the block SHALL pulse wr_ready for 1 cycle and latch wr_data.
REQ-033 WRITE SHALL shift 8 bits MSB first, then enter WRITE_ACK.
REQ-034 In WRITE_ACK, NACK SHALL set nack and go to STOP; on ACK the byte counter SHALL decrement, going to STOP at 0, else back to WRITE.
REQ-035 READ SHALL release sda_out and shift in 8 bits MSB first.
REQ-036 At READ completion, rd_data SHALL be updated and rd_valid pulsed in the same cycle.
REQ-037 In READ_ACK, the master SHALL drive sda_out=0 (ACK) for every byte except the last, and 1 (NACK) for the last; the last byte SHALL NOT set nack.
REQ-038 STOP SHALL drive sda_out=0 with sclk=0 for 1 tick, sclk=1 for 1 tick, then sda_out=1 with sclk=1 for 2 ticks.
REQ-039 On STOP exit, the block SHALL pulse done, clear busy, and enter IDLE.
REQ-040 nack SHALL hold its value until the next command accept, where it SHALL clear.
REQ-041 The byte counter SHALL be LEN_W bits; the maximum len of 2^LEN_W-1 SHALL transfer exactly that many bytes with no wrap.
REQ-042 cmd_valid while busy SHALL be ignored, and the command SHALL NOT be queued.
REQ-043 wr_valid outside WRITE byte starts SHALL be ignored.

Reset
REQ-044 When rst=1 at a clk edge, on that edge the block SHALL set:
  - state=IDLE, sclk=1, sda_out=1
  - busy=0, done=0, nack=0
  - rd_valid=0, wr_ready=0, rd_data=0
  - byte, bit and tick counters = 0
REQ-045 Reset mid-transfer SHALL abort with no STOP generated and no done pulse.
REQ-046 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-047 Write test, CLK_DIV=2, addr 0x5A, rw=0, len=2, data 0xA5,0x3C, slave ACKs all.
  - SDA bit sequence: 0xB4, ACK, 0xA5, ACK, 0x3C, ACK, then STOP.
  - Two wr_ready pulses; done=1; nack=0.
  - Each bit = 8 clk cycles.
REQ-048 Read test, addr 0x5A, len=3, slave returns 0x11,0x22,0x33.
  - Address byte 0xB5.
  - rd_valid pulses with 0x11, 0x22, 0x33.
  - Master ACK, ACK, then NACK; nack=0.
REQ-049 Address NACK: slave leaves sda_in=1 at ADDR_ACK -> STOP, done with nack=1, zero wr_ready pulses.
REQ-050 Probe len=0 with ACK: START, 0xB4 or 0xB5, ACK, STOP; done with nack=0.
REQ-051 wr_valid held low 20 cycles at the second byte start: sclk stays 0 for those 20 cycles, then the transfer completes correctly.
REQ-052 rst pulsed during the 4th address bit: next cycle sclk=1, sda_out=1, state=0, busy=0, no done; a new command then runs normally.
